stream_sorter: RTL and testbench

Parametrised AXI-Stream frame sorter, successor to the single-width bubble-sort block in the sort package. It accepts a frame of up to DEPTH words, sorts it in place with a fixed-latency odd-even transposition network, and streams the sorted frame out on a fully compliant AXI-Stream master port. New over the previous generation: run-time ascending/descending mode, signed/unsigned keys, overflow draining, backpressure-safe output and deterministic latency.

---
 rtl/stream_sorter.sv | 126 ++++++++++++
 tb/tb_stream_sorter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/stream_sorter.sv
// stream_sorter: AXI-Stream frame sorter using an odd-even transposition network.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   mode                0 ascending, 1 descending (latched on first beat of a frame)
//   s_tvalid/s_tready/s_tdata/s_tlast   input frame slave port
//   m_tvalid/m_tready/m_tdata/m_tlast   sorted frame master port
//   busy                high whenever not idle
//   overflow            frame had more than DEPTH words (extra words discarded)
//   frame_len           words stored for the current frame
module stream_sorter #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mode,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [WIDTH-1:0]           s_tdata,
    input  logic                       s_tlast,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [WIDTH-1:0]           m_tdata,
    output logic                       m_tlast,
    output logic                       busy,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     frame_len
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, DRAIN = 3'd2, SORT = 3'd3, OUT = 3'd4;
    logic [2:0]       state_q, state_d;
    logic [LW-1:0]    len_q, len_d, p_q, p_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic             mode_q, mode_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             in_hs, out_hs;

    function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return SIGNED ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    assign s_tready  = !reset && (state_q == IDLE || state_q == DRAIN ||
                                  (state_q == LOAD && len_q < LW'(DEPTH)));
    assign m_tvalid  = state_q == OUT;
    assign m_tdata   = m_tvalid ? mem_q[rd_q] : '0;
    assign m_tlast   = m_tvalid && ({1'b0, rd_q} == len_q - LW'(1));
    assign busy      = state_q != IDLE;
    assign overflow  = ovf_q;
    assign frame_len = len_q;
    assign in_hs     = s_tvalid && s_tready;
    assign out_hs    = m_tvalid && m_tready;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        p_d     = p_q;
        rd_d    = rd_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: if (in_hs) begin
                mem_d[0] = s_tdata;
                len_d    = LW'(1);
                mode_d   = mode;
                ovf_d    = 1'b0;
                p_d      = '0;
                state_d  = s_tlast ? SORT : LOAD;
            end
            LOAD: if (in_hs) begin
                mem_d[len_q[AW-1:0]] = s_tdata;
                len_d   = len_q + LW'(1);
                state_d = s_tlast ? SORT : (len_q == LW'(DEPTH - 1)) ? DRAIN : LOAD;
            end
            DRAIN: if (in_hs) begin
                ovf_d   = 1'b1;
                state_d = s_tlast ? SORT : DRAIN;
            end
            SORT: begin
                // Pairs of one parity are disjoint, so every swap reads the registered array.
                for (int i = 0; i < DEPTH - 1; i++)
                    if (i[0] == p_q[0] && LW'(i + 1) < len_q &&
                        (mode_q ? gt(mem_q[i+1], mem_q[i]) : gt(mem_q[i], mem_q[i+1]))) begin
                        mem_d[i]   = mem_q[i+1];
                        mem_d[i+1] = mem_q[i];
                    end
                p_d = p_q + LW'(1);
                if (p_q == len_q - LW'(1)) begin
                    state_d = OUT;
                    rd_d    = '0;
                end
            end
            OUT: if (out_hs) begin
                rd_d = rd_q + AW'(1);
                if (m_tlast) begin
                    state_d = IDLE;
                    len_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            p_q     <= '0;
            rd_q    <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            p_q     <= p_d;
            rd_q    <= rd_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_stream_sorter.sv
// tb_stream_sorter: directed self-checking bench for stream_sorter.
module tb_stream_sorter;
    logic clk = 1'b0, reset = 1'b1, mode = 1'b0;
    logic s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;
    logic [15:0] s_tdata = '0;
    logic s_tready, m_tvalid, m_tlast, busy, overflow;
    logic [15:0] m_tdata;
    logic [3:0] frame_len;
    logic mode_s = 1'b0, mode_u = 1'b0, v8 = 1'b0, l8 = 1'b0;
    logic [7:0] d8 = '0;
    logic rs_ready, rs_valid, rs_last, rs_busy, rs_ovf;
    logic ru_ready, ru_valid, ru_last, ru_busy, ru_ovf;
    logic [7:0] rs_data, ru_data;
    logic [3:0] rs_len, ru_len;
    int pass_cnt = 0, total = 0;
    int tx[$], ex[$], exs[$], exu[$];

    always #5 clk = ~clk;

    stream_sorter #(.WIDTH(16), .DEPTH(8), .SIGNED(1'b0)) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .busy(busy), .overflow(overflow), .frame_len(frame_len));

    stream_sorter #(.WIDTH(8), .DEPTH(8), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .mode(mode_s),
        .s_tvalid(v8), .s_tready(rs_ready), .s_tdata(d8), .s_tlast(l8),
        .m_tvalid(rs_valid), .m_tready(1'b1), .m_tdata(rs_data), .m_tlast(rs_last),
        .busy(rs_busy), .overflow(rs_ovf), .frame_len(rs_len));

    stream_sorter #(.WIDTH(8), .DEPTH(8), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .mode(mode_u),
        .s_tvalid(v8), .s_tready(ru_ready), .s_tdata(d8), .s_tlast(l8),
        .m_tvalid(ru_valid), .m_tready(1'b1), .m_tdata(ru_data), .m_tlast(ru_last),
        .busy(ru_busy), .overflow(ru_ovf), .frame_len(ru_len));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // mode is only valid on the first beat; it is inverted afterwards to prove it is latched.
    task automatic send(input logic md);
        for (int i = 0; i < tx.size(); i++) begin
            mode     = (i == 0) ? md : ~md;
            s_tvalid = 1'b1;
            s_tdata  = 16'(tx[i]);
            s_tlast  = (i == tx.size() - 1);
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        mode     = md;
    endtask

    task automatic recv(input int lat, input bit rnd);
        int n;
        int g;
        n = 0;
        while (!m_tvalid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, lat);
        for (int i = 0; i < ex.size(); i++) begin
            g = 0;
            do begin
                m_tready = (rnd && g < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
                check("m_tvalid", {31'd0, m_tvalid}, 1);
                check("m_tdata", {16'd0, m_tdata}, ex[i]);
                check("m_tlast", {31'd0, m_tlast}, (i == ex.size() - 1) ? 1 : 0);
                @(posedge clk); #1;
                g++;
            end while (!m_tready);
        end
        m_tready = 1'b1;
        check("idle_after_frame", {30'd0, busy, m_tvalid}, 0);
    endtask

    initial begin
        int n;
        logic seen;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_tready", {31'd0, s_tready}, 0);
        check("rst_m_tvalid", {31'd0, m_tvalid}, 0);
        check("rst_m_tdata", {16'd0, m_tdata}, 0);
        check("rst_m_tlast", {31'd0, m_tlast}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        check("rst_frame_len", {28'd0, frame_len}, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_s_tready", {31'd0, s_tready}, 1);

        tx = '{5, 3, 9, 1, 7};
        send(1'b0);
        check("t1_frame_len", {28'd0, frame_len}, 5);
        check("t1_busy", {31'd0, busy}, 1);
        check("t1_sort_s_tready", {31'd0, s_tready}, 0);
        ex = '{1, 3, 5, 7, 9};
        recv(5, 1'b0);

        tx = '{3, 7, 7, 1};
        send(1'b1);
        ex = '{7, 7, 3, 1};
        recv(4, 1'b0);

        exs = '{8'h7F, 8'h05, 8'hFF, 8'h80};
        exu = '{8'h05, 8'h7F, 8'h80, 8'hFF};
        tx  = '{8'h05, 8'hFF, 8'h80, 8'h7F};
        for (int i = 0; i < 4; i++) begin
            mode_s = (i == 0) ? 1'b1 : 1'b0;
            mode_u = (i == 0) ? 1'b0 : 1'b1;
            v8 = 1'b1;
            d8 = 8'(tx[i]);
            l8 = (i == 3);
            @(posedge clk); #1;
        end
        v8 = 1'b0;
        l8 = 1'b0;
        n = 0;
        while (!rs_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("w8_latency", n, 4);
        for (int i = 0; i < 4; i++) begin
            check("w8s_valid", {31'd0, rs_valid}, 1);
            check("w8s_data", {24'd0, rs_data}, exs[i]);
            check("w8s_last", {31'd0, rs_last}, (i == 3) ? 1 : 0);
            check("w8u_valid", {31'd0, ru_valid}, 1);
            check("w8u_data", {24'd0, ru_data}, exu[i]);
            check("w8u_last", {31'd0, ru_last}, (i == 3) ? 1 : 0);
            @(posedge clk); #1;
        end
        check("w8_idle", {28'd0, rs_busy, ru_busy, rs_valid, ru_valid}, 0);
        check("w8_no_ovf", {30'd0, rs_ovf, ru_ovf}, 0);

        tx = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        send(1'b0);
        check("ovf_flag", {31'd0, overflow}, 1);
        check("ovf_frame_len", {28'd0, frame_len}, 8);
        ex = '{3, 4, 5, 6, 7, 8, 9, 10};
        recv(8, 1'b0);
        check("ovf_held", {31'd0, overflow}, 1);

        tx = '{8, 7, 6, 5, 4, 3, 2, 1};
        send(1'b0);
        check("full_no_ovf", {31'd0, overflow}, 0);
        check("full_frame_len", {28'd0, frame_len}, 8);
        ex = '{1, 2, 3, 4, 5, 6, 7, 8};
        recv(8, 1'b0);

        tx = '{16'h1234};
        send(1'b0);
        check("one_frame_len", {28'd0, frame_len}, 1);
        ex = '{16'h1234};
        recv(1, 1'b0);

        tx = '{4, 4, 2, 4};
        send(1'b0);
        ex = '{2, 4, 4, 4};
        recv(4, 1'b1);

        tx = '{6, 5, 4, 3, 2, 1};
        send(1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_m_tvalid", {31'd0, m_tvalid}, 0);
        check("mid_rst_frame_len", {28'd0, frame_len}, 0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            seen = seen | m_tvalid;
        end
        check("no_out_after_rst", {31'd0, seen}, 0);
        tx = '{2, 1};
        send(1'b0);
        ex = '{1, 2};
        recv(2, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
